// File: rtl/cwc_capture_dump.sv
// ChipWatcher capture-and-readout engine.
// Samples the probe word into a circular buffer, triggers on a masked match,
// then streams the window around the trigger out over valid/ready.
module cwc_capture_dump #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 2048,
    parameter int ADDR_W   = 11,
    parameter int PRE_TRIG = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] probe_data,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic              arm,
    input  logic              abort,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic [2:0]        state,
    output logic              done
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DUMP = 3'd4;

    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam logic [ADDR_W:0]   PRE_LAST  = (ADDR_W+1)'(PRE_TRIG - 1);
    localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W+1)'(POST_N - 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] p_q, mem_q, skid_data;
    logic [ADDR_W-1:0] wr_ptr, trig_addr, rd_ptr, start_addr;
    logic [ADDR_W:0]   cnt, rd_left;
    logic              match, wr_en, enter_dump, issue, pop;
    logic              ram_vld, ram_last, skid_vld, skid_last;
    logic [1:0]        occ;

    assign match   = ((p_q ^ trig_value) & trig_mask) == '0;
    assign wr_en   = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign pop     = rd_valid && rd_ready;
    // The trigger address is still in wr_ptr when WAIT jumps straight to DUMP.
    assign start_addr = ((state == S_WAIT) ? wr_ptr : trig_addr) - PRE_OFS;
    assign enter_dump = !abort &&
                        ((state == S_WAIT && match && POST_N == 0) ||
                         (state == S_POST && cnt == POST_LAST));
    // Words in flight or buffered; keep at most two so the skid never overflows.
    assign occ   = 2'(rd_valid) + 2'(skid_vld) + 2'(ram_vld);
    assign issue = (state == S_DUMP) && !abort && (rd_left != '0) &&
                   ((occ - 2'(pop)) < 2'd2);

    // Probe input register shared by the RAM write and the trigger compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_q <= '0;
        else     p_q <= probe_data;
    end

    // Buffer RAM: write port from the capture side, registered read for the dump.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= p_q;
        mem_q <= mem[rd_ptr];
    end

    // Capture FSM: pre-fill, wait for trigger, post-fill, dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            cnt       <= '0;
            trig_addr <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (arm) begin
                        wr_ptr <= '0;
                        cnt    <= '0;
                        state  <= (PRE_TRIG == 0) ? S_WAIT : S_PRE;
                    end
                    S_PRE: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == PRE_LAST) state <= S_WAIT;
                    end
                    S_WAIT: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (match) begin
                            trig_addr <= wr_ptr;
                            cnt       <= '0;
                            state     <= (POST_N == 0) ? S_DUMP : S_POST;
                        end
                    end
                    S_POST: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == POST_LAST) state <= S_DUMP;
                    end
                    S_DUMP: if (pop && rd_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Read address generator: load the window start, then issue one read per credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            rd_left <= '0;
        end else if (enter_dump) begin
            rd_ptr  <= start_addr;
            rd_left <= DEPTH_C;
        end else if (issue) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_left <= rd_left - 1'b1;
        end
    end

    // Output stage: output register plus one skid entry absorbs the read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_vld   <= 1'b0;
            ram_last  <= 1'b0;
            skid_vld  <= 1'b0;
            skid_last <= 1'b0;
            skid_data <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else if (abort) begin
            ram_vld  <= 1'b0;
            skid_vld <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            ram_vld  <= issue;
            ram_last <= issue && (rd_left == (ADDR_W+1)'(1));
            if (!rd_valid || pop) begin
                if (skid_vld) begin
                    rd_data   <= skid_data;
                    rd_last   <= skid_last;
                    rd_valid  <= 1'b1;
                    skid_vld  <= ram_vld;
                    skid_data <= mem_q;
                    skid_last <= ram_last;
                end else if (ram_vld) begin
                    rd_data  <= mem_q;
                    rd_last  <= ram_last;
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end
            end else if (ram_vld) begin
                skid_vld  <= 1'b1;
                skid_data <= mem_q;
                skid_last <= ram_last;
            end
        end
    end
endmodule

// File: tb/tb_cwc_capture_dump.sv
// Scoreboard bench for cwc_capture_dump: instance 0 with PRE_TRIG=512,
// instance 1 with PRE_TRIG=0. Expected dump windows are computed from the
// probe history function and queued at arm time; monitors pop on handshakes.
module tb_cwc_capture_dump;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [63:0] probe_data = '0, trig_value = '0, trig_mask = '0;
    logic arm [2], abort_s [2], rd_ready [2], rd_valid [2], rd_last [2], done [2];
    logic [63:0] rd_data [2];
    logic [2:0]  state [2];

    int total = 0, bad = 0, cyc = 0, duty = 100;
    int unsigned seed;
    logic [64:0] q0 [$], q1 [$];

    always #5 clk = ~clk;

    cwc_capture_dump #(.PRE_TRIG(512)) u0 (
        .clk(clk), .rst(rst), .probe_data(probe_data), .trig_value(trig_value),
        .trig_mask(trig_mask), .arm(arm[0]), .abort(abort_s[0]), .rd_data(rd_data[0]),
        .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_last(rd_last[0]),
        .state(state[0]), .done(done[0]));

    cwc_capture_dump #(.PRE_TRIG(0)) u1 (
        .clk(clk), .rst(rst), .probe_data(probe_data), .trig_value(trig_value),
        .trig_mask(trig_mask), .arm(arm[1]), .abort(abort_s[1]), .rd_data(rd_data[1]),
        .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_last(rd_last[1]),
        .state(state[1]), .done(done[1]));

    // Probe value seen at cycle c: low half is a ramp, high half a seeded hash.
    function automatic logic [63:0] probe_at(int c);
        logic [31:0] lo;
        lo = 32'(c);
        return {(lo * 32'h9E3779B1) ^ seed, lo};
    endfunction

    function automatic void qpush(int i, logic [64:0] v);
        if (i == 0) q0.push_back(v); else q1.push_back(v);
    endfunction
    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction
    function automatic logic [64:0] qpop(int i);
        return (i == 0) ? q0.pop_front() : q1.pop_front();
    endfunction
    function automatic void qclear(int i);
        if (i == 0) q0.delete(); else q1.delete();
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        probe_data = probe_at(cyc);
        rd_ready[0] = ($urandom_range(99) < duty);
        rd_ready[1] = ($urandom_range(99) < duty);
    endtask

    // Model: samples captured are probe_at(a), probe_at(a+1), ...; the trigger is
    // the first sample at index >= pt that matches; the window is pt samples before it.
    task automatic start_capture(int i, int pt, logic [63:0] val, logic [63:0] msk, bit push);
        int a, t;
        a = cyc;
        t = -1;
        trig_value = val;
        trig_mask  = msk;
        for (int c = a + pt; c < a + pt + 20000; c++)
            if (((probe_at(c) ^ val) & msk) == 64'd0) begin t = c; break; end
        if (t < 0) chk("model_trigger_found", 64'd0, 64'd1);
        else if (push)
            for (int k = 0; k < DEPTH; k++)
                qpush(i, {(k == DEPTH - 1), probe_at(t - pt + k)});
        arm[i] = 1'b1;
        step();
        arm[i] = 1'b0;
        chk("state_after_arm", 64'(state[i]), (pt == 0) ? 64'd2 : 64'd1);
    endtask

    task automatic finish_capture(int i);
        int n = 0;
        while ((qsize(i) != 0 || state[i] != 3'd0) && n < 30000) begin step(); n++; end
        if (n >= 30000) chk("dump_timeout", 64'(qsize(i)), 64'd0);
        step(); step();
    endtask

    task automatic wait_cond_state(int i, logic [2:0] s);
        int n = 0;
        while (state[i] != s && n < 20000) begin step(); n++; end
        if (n >= 20000) chk("wait_state_timeout", 64'(state[i]), 64'(s));
    endtask

    task automatic wait_qbelow(int i, int lim);
        int n = 0;
        while (qsize(i) >= lim && n < 30000) begin step(); n++; end
        if (n >= 30000) chk("wait_words_timeout", 64'(qsize(i)), 64'(lim));
    endtask

    task automatic do_abort(int i);
        abort_s[i] = 1'b1;
        step();
        abort_s[i] = 1'b0;
        chk("abort_state", 64'(state[i]), 64'd0);
        chk("abort_valid", 64'(rd_valid[i]), 64'd0);
        qclear(i);
        repeat (4) step();
    endtask

    // Monitor: pops the scoreboard on each handshake, checks stall stability and done timing.
    task automatic monitor(int i);
        logic pstall = 1'b0, pl = 1'b0, edone = 1'b0;
        logic [63:0] pd = '0;
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin pstall = 1'b0; edone = 1'b0; continue; end
            if (edone) begin
                chk("done_pulse_and_idle", {60'd0, state[i], done[i]}, 64'd1);
                edone = 1'b0;
            end else if (done[i]) begin
                chk("spurious_done", 64'(done[i]), 64'd0);
            end
            if (pstall)
                chk("stall_stable", {rd_data[i] ^ pd}, {63'd0, ~(rd_valid[i] && (rd_last[i] == pl))});
            if (rd_valid[i] && rd_ready[i]) begin
                if (qsize(i) == 0) chk("unexpected_word", rd_data[i], 64'hdead);
                else begin
                    e = qpop(i);
                    chk("dump_word", rd_data[i], e[63:0]);
                    chk("dump_last", 64'(rd_last[i]), 64'(e[64]));
                    if (rd_last[i]) edone = 1'b1;
                end
            end
            pstall = rd_valid[i] && !rd_ready[i] && !abort_s[i];
            pd = rd_data[i];
            pl = rd_last[i];
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        int a;
        seed = $urandom;
        for (int i = 0; i < 2; i++) begin
            arm[i] = 1'b0; abort_s[i] = 1'b0; rd_ready[i] = 1'b1;
        end
        probe_data = probe_at(0);
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("reset_state", 64'(state[i]), 64'd0);
            chk("reset_outputs", {rd_data[i][61:0], rd_valid[i], rd_last[i]}, 64'd0);
            chk("reset_done", 64'(done[i]), 64'd0);
        end
        rst = 1'b0;
        step();

        // Ramp capture: trigger 2900 samples after arm, full ready.
        a = cyc;
        start_capture(0, 512, probe_at(a + 2900), '1, 1'b1);
        finish_capture(0);

        // Low-12-bit match lands inside PRE first and must be ignored.
        a = cyc;
        start_capture(0, 512, probe_at(a + 100) & 64'hFFF, 64'hFFF, 1'b1);
        finish_capture(0);

        // PRE_TRIG=0 with all-zero mask: triggers on the first WAIT sample.
        start_capture(1, 0, $urandom, 64'd0, 1'b1);
        finish_capture(1);

        // Backpressure at 30% ready duty.
        duty = 30;
        a = cyc;
        start_capture(0, 512, probe_at(a + 600 + $urandom_range(3000)), '1, 1'b1);
        finish_capture(0);

        // Random low-bit masks and values on both instances, random duty.
        for (int i = 0; i < 2; i++) begin
            duty = 30 + $urandom_range(70);
            start_capture(i, (i == 0) ? 512 : 0, {$urandom, $urandom},
                          {32'd0, 32'($urandom_range(1023))}, 1'b1);
            finish_capture(i);
        end

        // Abort in POST, then a clean capture.
        duty = 60;
        a = cyc;
        start_capture(0, 512, probe_at(a + 700), '1, 1'b0);
        wait_cond_state(0, 3'd3);
        do_abort(0);
        a = cyc;
        start_capture(0, 512, probe_at(a + 800), '1, 1'b1);
        finish_capture(0);

        // Abort mid-DUMP, then a clean capture.
        a = cyc;
        start_capture(0, 512, probe_at(a + 900), '1, 1'b1);
        wait_qbelow(0, DEPTH - 100);
        do_abort(0);
        a = cyc;
        start_capture(0, 512, probe_at(a + 1000), '1, 1'b1);
        finish_capture(0);

        // Asynchronous reset mid-DUMP with arm held high during reset.
        a = cyc;
        start_capture(0, 512, probe_at(a + 1100), '1, 1'b1);
        wait_qbelow(0, DEPTH - 50);
        #3;
        rst = 1'b1;
        arm[0] = 1'b1;
        #1;
        chk("async_reset_state", 64'(state[0]), 64'd0);
        chk("async_reset_outputs", {rd_data[0][61:0], rd_valid[0], rd_last[0]}, 64'd0);
        chk("async_reset_done", 64'(done[0]), 64'd0);
        qclear(0);
        repeat (3) step();
        arm[0] = 1'b0;
        rst = 1'b0;
        step();
        chk("arm_ignored_in_reset", 64'(state[0]), 64'd0);
        a = cyc;
        start_capture(0, 512, probe_at(a + 1200), '1, 1'b1);
        finish_capture(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cwc_capture_dump.md
# cwc_capture_dump

Capture-and-readout engine for the on-chip ChipWatcher probe bus: samples the 64-bit concatenated probe word (one 4-bit bus plus six 10-bit buses) every clock into a 2048-deep circular buffer, triggers on a masked value match, then streams the captured window out over a valid/ready interface. It sits between the probe taps in the HDMI/face pipeline and the host-side debug link. It is the reader/consumer end of the probe bus that the ChipWatcher instance drives.

## Interface
Parameters:
- DATA_W, 64, probe word width (4 + 6×10)
- DEPTH, 2048, capture buffer depth in words; power of two
- ADDR_W, 11, log2(DEPTH)
- PRE_TRIG, 512, samples retained before the trigger sample; 0 ≤ PRE_TRIG ≤ DEPTH-1

Ports:
- clk  in  1  sole clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- probe_data  in  DATA_W  concatenated probe word, sampled every cycle
- trig_value  in  DATA_W  trigger compare value; static while armed
- trig_mask  in  DATA_W  1 = bit participates in the compare
- arm  in  1  single-cycle start pulse, honoured only in IDLE
- abort  in  1  return to IDLE from any state
- rd_data  out  DATA_W  captured word, oldest first
- rd_valid  out  1  rd_data is valid
- rd_ready  in  1  consumer accepts rd_data
- rd_last  out  1  qualifies the final word, word DEPTH-1
- state  out  3  IDLE=0, PRE=1, WAIT=2, POST=3, DUMP=4
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- probe_data passes through one input register (p_q). Both the RAM write and the trigger compare use p_q.
- Trigger condition: ((p_q ^ trig_value) & trig_mask) == 0. An all-zero mask matches on every cycle.
- States:
  - IDLE: no writes. On arm, clear the write pointer and pre-counter, then go to PRE.
  - PRE: write p_q every cycle and increment the pre-counter. After PRE_TRIG writes, go to WAIT. Triggers are ignored in PRE. When PRE_TRIG = 0, go directly from IDLE to WAIT.
  - WAIT: write every cycle; the pointer wraps modulo DEPTH. On the first matching cycle, the matching sample is written, its address is latched as trig_addr, and the FSM goes to POST.
  - POST: write DEPTH-PRE_TRIG-1 further samples, then go to DUMP. When that count is 0, go from WAIT straight to DUMP.
  - DUMP: no writes. Read DEPTH words starting at start_addr = (trig_addr - PRE_TRIG) mod DEPTH, incrementing modulo DEPTH. rd_last accompanies the DEPTH-th word. When that word is accepted, pulse done and go to IDLE.
- Handshake:
  - A word transfers on a cycle where rd_valid && rd_ready.
  - While rd_valid is high and rd_ready is low, rd_data and rd_last hold stable and rd_valid stays high.
  - rd_valid never drops mid-dump except on abort or reset.
- The RAM is a single-clock simple dual-port with a 1-cycle registered read. The output stage uses prefetch or skid logic so the RAM read latency never stalls the stream.
- abort has priority over every other transition. The FSM goes to IDLE next cycle, rd_valid deasserts next cycle, done is not pulsed, and buffer contents are don't-care.
- arm outside IDLE is ignored. arm and abort in the same cycle in IDLE: abort wins and the FSM stays in IDLE.
- Address and counter arithmetic is unsigned, ADDR_W bits, wrapping naturally. The pre-counter and post-counter are ADDR_W+1 bits so a count of DEPTH-1 never overflows.

## Timing
- Reset values: state=IDLE, rd_valid=0, rd_last=0, done=0, rd_data=0, pointers/counters=0.
- Probe to RAM write: 1 cycle, the sample at edge N is written at edge N+1.
- A trigger match on p_q at cycle T means the FSM is in POST at cycle T+1.
- From arm to WAIT: PRE_TRIG+1 cycles after the arm edge.
- First rd_valid: at most 2 cycles after entering DUMP.
- With rd_ready held high, one word per cycle. A full dump of DEPTH words takes DEPTH cycles after the first rd_valid.
- done pulses on the cycle after the rd_last handshake. state reads IDLE on that same cycle.
- state is registered and changes only on clock edges.

## Test plan
- Counter ramp: probe_data = cycle count, PRE_TRIG=512, mask=all ones, value=3000, arm at count 100. Dump must contain 2488..4535 in order, word 512 = 3000, rd_last on word 2047, done one cycle later.
- Trigger during PRE ignored: value matches count 200 then 5000, arm at 100. trig_addr must correspond to 5000, and word 512 = 5000.
- All-zero mask with PRE_TRIG=0: trigger fires on the first WAIT cycle. The dump's first word is the sample that follows arm by one cycle.
- Backpressure: random rd_ready at 30% duty. rd_data and rd_last must be stable while stalled, with no dropped or duplicated words (2048 unique ramp values).
- Abort in POST and in mid-DUMP: next cycle state=IDLE and rd_valid=0, done never pulses. A following arm runs a clean capture.
- Reset mid-DUMP: asynchronous rst asserted between edges. Outputs go to reset values immediately, and arm ignored during reset.
